// File: rtl/recon_seq_pkg.sv
// Shared definitions for the recon_io pattern sequencer: step opcodes,
// FSM state encoding, slave register offsets and CMD word field positions.
package recon_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_WAIT_IRQ = 2'd1,
    OP_END      = 2'd2,
    OP_LOOP     = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DELAY,
    ST_WAITIRQ
  } state_t;

  // Slave register offsets (word addresses); bit 5 set selects the step table
  localparam logic [5:0] REG_CTRL   = 6'd0;
  localparam logic [5:0] REG_STATUS = 6'd1;
  localparam logic [5:0] REG_STEP   = 6'd2;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_STOP   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_DONE   = 1;

  // CMD word layout: {DELAY[31:16], reserved[15:8], OP[7:6], ADDR[5:0]}
  localparam int unsigned CMD_ADDR_LSB  = 0;
  localparam int unsigned CMD_ADDR_W    = 6;
  localparam int unsigned CMD_OP_LSB    = 6;
  localparam int unsigned CMD_DELAY_LSB = 16;

  // Width of the step index for a table of the given depth
  function automatic int unsigned step_w(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  function automatic logic [31:0] make_cmd(input logic [15:0] dly, input op_t op,
                                           input logic [5:0] addr);
    return {dly, 8'h00, op, addr};
  endfunction

endpackage

// File: rtl/recon_seq_table.sv
// Step table for the recon_io sequencer: 2*STEPS words of 32 bits.
// Word 2i is step i DATA, word 2i+1 is step i CMD.
// Ports:
//   clk      in   clock
//   i_we     in   slave write enable (table region already decoded)
//   i_waddr  in   slave word index within the table region
//   i_wdata  in   slave write data
//   i_raddr  in   slave read word index
//   o_rdata  out  slave read data, 0 for indices beyond the table
//   i_fidx   in   step index used by FETCH
//   o_fdata  out  DATA word of step i_fidx
//   o_fcmd   out  CMD word of step i_fidx
module recon_seq_table
  import recon_seq_pkg::*;
#(
  parameter int unsigned STEPS = 16
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [4:0]                 i_waddr,
  input  logic [31:0]                i_wdata,
  input  logic [4:0]                 i_raddr,
  output logic [31:0]                o_rdata,
  input  logic [step_w(STEPS)-1:0]   i_fidx,
  output logic [31:0]                o_fdata,
  output logic [31:0]                o_fcmd
);

  localparam int unsigned DEPTH = 2 * STEPS;
  localparam int unsigned AW    = step_w(STEPS) + 1;
  localparam logic [5:0]  DEPTH6 = 6'(DEPTH);

  logic [31:0] r_mem [DEPTH];
  logic        w_wr_ok;
  logic        w_rd_ok;

  assign w_wr_ok = i_we && ({1'b0, i_waddr} < DEPTH6);
  assign w_rd_ok = ({1'b0, i_raddr} < DEPTH6);

  // No reset: table contents are undefined until the CPU loads them
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[i_waddr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = w_rd_ok ? r_mem[i_raddr[AW-1:0]] : '0;
  assign o_fdata = r_mem[{i_fidx, 1'b0}];
  assign o_fcmd  = r_mem[{i_fidx, 1'b1}];

endmodule

// File: rtl/recon_io_seq.sv
// Autonomous pattern sequencer driving one recon_io port over Avalon-MM.
// The CPU loads a step table and starts the sequencer, which then issues
// timed master writes, waits on io_irq, loops or ends on its own.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   s_address/s_chipselect/s_write/s_read/s_writedata  CPU slave inputs
//   s_readdata                      registered read data (1-cycle latency)
//   m_address/m_chipselect/m_write/m_writedata  master write to recon_io
//   m_waitrequest                   recon_io stall
//   io_irq                          recon_io interrupt, consumed by WAIT_IRQ
//   irq                             sequence-done interrupt (DONE & IRQ_EN)
module recon_io_seq
  import recon_seq_pkg::*;
#(
  parameter int unsigned STEPS       = 16,
  parameter int unsigned DELAY_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write,
  input  logic        s_read,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [5:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  input  logic        io_irq,
  output logic        irq
);

  localparam int unsigned SW = step_w(STEPS);

  state_t                 r_state;
  state_t                 w_next;
  logic [SW-1:0]          r_step;
  logic [31:0]            r_cmd;
  logic [31:0]            r_data;
  logic [DELAY_WIDTH-1:0] r_cnt;
  logic                   r_done;
  logic                   r_irq_en;
  logic                   r_irq;
  logic                   r_stop_pend;
  logic [31:0]            r_readdata;

  logic        w_ctrl_wr, w_status_wr, w_tbl_we;
  logic        w_start, w_stop, w_busy, w_issue;
  logic        w_step_clr, w_step_inc, w_set_done, w_latch, w_load_cnt, w_dec;
  logic [31:0] w_fetch_data, w_fetch_cmd, w_tbl_rdata, w_rdmux;
  op_t         w_fetch_op;
  logic        w_unused_cmd;

  assign w_ctrl_wr   = s_chipselect && s_write && (s_address == REG_CTRL);
  assign w_status_wr = s_chipselect && s_write && (s_address == REG_STATUS);
  assign w_tbl_we    = s_chipselect && s_write && s_address[5];
  assign w_stop      = w_ctrl_wr && s_writedata[CTRL_STOP];
  assign w_start     = w_ctrl_wr && s_writedata[CTRL_START] && !s_writedata[CTRL_STOP];
  assign w_busy      = (r_state != ST_IDLE);
  assign w_issue     = (r_state == ST_ISSUE);

  recon_seq_table #(
    .STEPS (STEPS)
  ) u_table (
    .clk     (clk),
    .i_we    (w_tbl_we),
    .i_waddr (s_address[4:0]),
    .i_wdata (s_writedata),
    .i_raddr (s_address[4:0]),
    .o_rdata (w_tbl_rdata),
    .i_fidx  (r_step),
    .o_fdata (w_fetch_data),
    .o_fcmd  (w_fetch_cmd)
  );

  // OP is decoded straight from the table so FETCH can branch in one cycle
  assign w_fetch_op = op_t'(w_fetch_cmd[CMD_OP_LSB +: 2]);

  always_comb begin
    w_next     = r_state;
    w_step_clr = 1'b0;
    w_step_inc = 1'b0;
    w_set_done = 1'b0;
    w_latch    = 1'b0;
    w_load_cnt = 1'b0;
    w_dec      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next     = ST_FETCH;
          w_step_clr = 1'b1;
        end
      end
      ST_FETCH: begin
        if (w_stop) begin
          w_next = ST_IDLE;
        end else begin
          w_latch = 1'b1;
          case (w_fetch_op)
            OP_WRITE:    w_next = ST_ISSUE;
            OP_WAIT_IRQ: w_next = ST_WAITIRQ;
            OP_END: begin
              w_next     = ST_IDLE;
              w_set_done = 1'b1;
            end
            OP_LOOP: begin
              w_next     = ST_FETCH;
              w_step_clr = 1'b1;
            end
            default: w_next = ST_IDLE;
          endcase
        end
      end
      ST_ISSUE: begin
        // A STOP seen during a stalled transfer is remembered and honoured
        // only once the transfer has been accepted
        if (!m_waitrequest) begin
          if (w_stop || r_stop_pend) begin
            w_next = ST_IDLE;
          end else begin
            w_next     = ST_DELAY;
            w_load_cnt = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        if (w_stop) begin
          w_next = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_next     = ST_FETCH;
          w_step_inc = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_WAITIRQ: begin
        if (w_stop) begin
          w_next = ST_IDLE;
        end else if (io_irq) begin
          w_next     = ST_DELAY;
          w_load_cnt = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rdmux = '0;
    if (s_address[5]) begin
      w_rdmux = w_tbl_rdata;
    end else begin
      case (s_address)
        REG_CTRL:   w_rdmux[CTRL_IRQ_EN] = r_irq_en;
        REG_STATUS: begin
          w_rdmux[STAT_BUSY] = w_busy;
          w_rdmux[STAT_DONE] = r_done;
        end
        REG_STEP:   w_rdmux = 32'(r_step);
        default:    w_rdmux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_cmd       <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
      r_stop_pend <= 1'b0;
      r_readdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_step_clr) begin
        r_step <= '0;
      end else if (w_step_inc) begin
        r_step <= (r_step == SW'(STEPS - 1)) ? '0 : r_step + SW'(1);
      end
      if (w_latch) begin
        r_cmd  <= w_fetch_cmd;
        r_data <= w_fetch_data;
      end
      if (w_load_cnt) begin
        r_cnt <= r_cmd[CMD_DELAY_LSB +: DELAY_WIDTH];
      end else if (w_dec) begin
        r_cnt <= r_cnt - DELAY_WIDTH'(1);
      end
      r_stop_pend <= w_issue && (r_stop_pend || w_stop);
      // Set has priority over a simultaneous write-1-to-clear
      if (w_set_done) begin
        r_done <= 1'b1;
      end else if (w_status_wr && s_writedata[STAT_DONE]) begin
        r_done <= 1'b0;
      end
      if (w_ctrl_wr) begin
        r_irq_en <= s_writedata[CTRL_IRQ_EN];
      end
      r_irq <= r_done && r_irq_en;
      if (s_chipselect && s_read) begin
        r_readdata <= w_rdmux;
      end
    end
  end

  assign w_unused_cmd = ^r_cmd;

  assign s_readdata   = r_readdata;
  assign irq          = r_irq;
  assign m_chipselect = w_issue;
  assign m_write      = w_issue;
  assign m_address    = w_issue ? r_cmd[CMD_ADDR_LSB +: CMD_ADDR_W] : '0;
  assign m_writedata  = w_issue ? r_data : '0;

endmodule

// File: tb/tb_recon_io_seq.sv
module tb_recon_io_seq;
  import recon_seq_pkg::*;

  typedef logic [37:0] xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [5:0]  s_address;
  logic        s_cs1, s_cs4, s_write, s_read;
  logic [31:0] s_writedata;
  logic [31:0] rd1, rd4;
  logic [5:0]  m_addr1, m_addr4;
  logic        m_cs1, m_cs4, m_wr1, m_wr4;
  logic [31:0] m_data1, m_data4;
  logic        wait1;
  logic        io_irq;
  logic        irq1, irq4;

  int total = 0;
  int bad   = 0;
  xfer_t exp1[$], obs1[$], exp4[$], obs4[$];

  recon_io_seq #(.STEPS(16), .DELAY_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .s_address(s_address), .s_chipselect(s_cs1),
    .s_write(s_write), .s_read(s_read), .s_writedata(s_writedata), .s_readdata(rd1),
    .m_address(m_addr1), .m_chipselect(m_cs1), .m_write(m_wr1), .m_writedata(m_data1),
    .m_waitrequest(wait1), .io_irq(io_irq), .irq(irq1)
  );

  recon_io_seq #(.STEPS(4), .DELAY_WIDTH(16)) u_dut4 (
    .clk(clk), .reset(reset), .s_address(s_address), .s_chipselect(s_cs4),
    .s_write(s_write), .s_read(s_read), .s_writedata(s_writedata), .s_readdata(rd4),
    .m_address(m_addr4), .m_chipselect(m_cs4), .m_write(m_wr4), .m_writedata(m_data4),
    .m_waitrequest(1'b0), .io_irq(io_irq), .irq(irq4)
  );

  // Accepted master transfers, sampled mid-cycle
  always @(negedge clk) begin
    if (m_cs1 && m_wr1 && !wait1) obs1.push_back({m_addr1, m_data1});
    if (m_cs4 && m_wr4) obs4.push_back({m_addr4, m_data4});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic wr(input bit sel, input logic [5:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    if (sel) s_cs4 = 1'b1; else s_cs1 = 1'b1;
    tick();
    s_write = 1'b0; s_cs1 = 1'b0; s_cs4 = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [5:0] a, output logic [31:0] d);
    s_address = a; s_read = 1'b1;
    if (sel) s_cs4 = 1'b1; else s_cs1 = 1'b1;
    tick();
    s_read = 1'b0; s_cs1 = 1'b0; s_cs4 = 1'b0;
    d = sel ? rd4 : rd1;
  endtask

  task automatic rd_chk(input bit sel, input logic [5:0] a, input logic [31:0] expv,
                        input string tag);
    logic [31:0] d;
    rd(sel, a, d);
    chk(tag, d, expv);
  endtask

  task automatic wait_obs(input bit sel, input int n, input int bound, input string tag);
    int k = 0;
    while (((sel ? obs4.size() : obs1.size()) < n) && (k < bound)) begin
      tick();
      k++;
    end
    chk(tag, 32'((sel ? obs4.size() : obs1.size()) >= n), 32'd1);
  endtask

  // Pops observed transfers against the expected queue; counts must match too
  task automatic sb_drain(input bit sel, input string tag);
    xfer_t e, o;
    if (!sel) begin
      chk({tag, "_count"}, 32'(obs1.size()), 32'(exp1.size()));
      while (exp1.size() > 0 && obs1.size() > 0) begin
        e = exp1.pop_front(); o = obs1.pop_front();
        chk({tag, "_addr"}, 32'(o[37:32]), 32'(e[37:32]));
        chk({tag, "_data"}, o[31:0], e[31:0]);
      end
      exp1.delete(); obs1.delete();
    end else begin
      chk({tag, "_count"}, 32'(obs4.size()), 32'(exp4.size()));
      while (exp4.size() > 0 && obs4.size() > 0) begin
        e = exp4.pop_front(); o = obs4.pop_front();
        chk({tag, "_addr"}, 32'(o[37:32]), 32'(e[37:32]));
        chk({tag, "_data"}, o[31:0], e[31:0]);
      end
      exp4.delete(); obs4.delete();
    end
  endtask

  initial begin
    int hold;
    reset = 1'b1; s_address = '0; s_cs1 = 1'b0; s_cs4 = 1'b0; s_write = 1'b0;
    s_read = 1'b0; s_writedata = '0; wait1 = 1'b0; io_irq = 1'b0;
    repeat (3) tick();
    chk("rst_mwrite", 32'(m_wr1), 32'd0);
    chk("rst_irq", 32'(irq1), 32'd0);
    chk("rst_readdata", rd1, 32'd0);
    reset = 1'b0;
    rd_chk(0, REG_STATUS, 32'd0, "rst_status");
    rd_chk(0, REG_STEP, 32'd0, "rst_step");

    // 1: single write then END, DONE and irq
    wr(0, 6'd32, 32'h5);
    wr(0, 6'd33, make_cmd(16'd3, OP_WRITE, 6'd1));
    wr(0, 6'd35, make_cmd(16'd0, OP_END, 6'd0));
    wr(0, REG_CTRL, 32'h4);
    rd_chk(0, REG_CTRL, 32'h4, "t1_irqen");
    exp1.push_back({6'd1, 32'h5});
    wr(0, REG_CTRL, 32'h5);
    chk("t1_T1_mwrite", 32'(m_wr1), 32'd0);
    tick();
    chk("t1_T2_mwrite", 32'(m_wr1), 32'd1);
    chk("t1_T2_maddr", 32'(m_addr1), 32'd1);
    chk("t1_T2_mdata", m_data1, 32'h5);
    // ISSUE 1 cycle, DELAY 4 cycles, FETCH(END) 1 cycle, then irq one cycle after DONE
    repeat (6) tick();
    chk("t1_irq_early", 32'(irq1), 32'd0);
    tick();
    chk("t1_irq", 32'(irq1), 32'd1);
    rd_chk(0, REG_STATUS, 32'h2, "t1_status");
    sb_drain(0, "t1");
    wr(0, REG_STATUS, 32'h2);
    rd_chk(0, REG_STATUS, 32'h0, "t1_w1c");
    chk("t1_irq_clr", 32'(irq1), 32'd0);

    // 2: waitrequest stalls the transfer for 4 cycles
    wr(0, REG_CTRL, 32'h0);
    wait1 = 1'b1;
    exp1.push_back({6'd1, 32'h5});
    wr(0, REG_CTRL, 32'h1);
    tick();
    hold = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_wr1 && m_cs1 && m_addr1 == 6'd1 && m_data1 == 32'h5) hold++;
      tick();
    end
    wait1 = 1'b0;
    if (m_wr1 && m_cs1 && m_addr1 == 6'd1 && m_data1 == 32'h5) hold++;
    tick();
    chk("t2_hold", 32'(hold), 32'd5);
    chk("t2_release", 32'(m_wr1), 32'd0);
    repeat (8) tick();
    rd_chk(0, REG_STATUS, 32'h2, "t2_status");
    sb_drain(0, "t2");
    wr(0, REG_STATUS, 32'h2);

    // 3: WRITE + LOOP, STOP after three iterations
    wr(0, 6'd32, 32'h1);
    wr(0, 6'd33, make_cmd(16'd0, OP_WRITE, 6'd3));
    wr(0, 6'd35, make_cmd(16'd0, OP_LOOP, 6'd0));
    for (int i = 0; i < 3; i++) exp1.push_back({6'd3, 32'h1});
    wr(0, REG_CTRL, 32'h1);
    wait_obs(0, 3, 40, "t3_wait");
    wr(0, REG_CTRL, 32'h2);
    repeat (6) tick();
    rd_chk(0, REG_STATUS, 32'h0, "t3_status");
    sb_drain(0, "t3");

    // 4: WAIT_IRQ gates the following write
    wr(0, 6'd33, make_cmd(16'd0, OP_WAIT_IRQ, 6'd0));
    wr(0, 6'd34, 32'hF);
    wr(0, 6'd35, make_cmd(16'd0, OP_WRITE, 6'd4));
    wr(0, 6'd37, make_cmd(16'd0, OP_END, 6'd0));
    exp1.push_back({6'd4, 32'hF});
    wr(0, REG_CTRL, 32'h1);
    repeat (18) tick();
    chk("t4_quiet", 32'(obs1.size()), 32'd0);
    rd_chk(0, REG_STATUS, 32'h1, "t4_busy");
    io_irq = 1'b1;
    tick();
    io_irq = 1'b0;
    wait_obs(0, 1, 10, "t4_wait");
    sb_drain(0, "t4");
    repeat (4) tick();
    rd_chk(0, REG_STATUS, 32'h2, "t4_status");
    wr(0, REG_STATUS, 32'h2);

    // START together with STOP is ignored
    wr(0, REG_CTRL, 32'h3);
    tick();
    rd_chk(0, REG_STATUS, 32'h0, "startstop_status");

    // 5: STEPS=4 instance, index wraps 3 -> 0 and parks on WAIT_IRQ at step 0
    wr(1, 6'd33, make_cmd(16'd0, OP_WAIT_IRQ, 6'd0));
    for (int i = 1; i < 4; i++) begin
      wr(1, 6'(32 + 2 * i), 32'h40 + 32'(i));
      wr(1, 6'(33 + 2 * i), make_cmd(16'd0, OP_WRITE, 6'(i)));
      exp4.push_back({6'(i), 32'h40 + 32'(i)});
    end
    wr(1, REG_CTRL, 32'h1);
    repeat (4) tick();
    io_irq = 1'b1;
    tick();
    io_irq = 1'b0;
    wait_obs(1, 3, 30, "t5_wait");
    repeat (4) tick();
    rd_chk(1, REG_STEP, 32'd0, "t5_step_wrap");
    rd_chk(1, REG_STATUS, 32'h1, "t5_busy");
    rd_chk(1, 6'd40, 32'd0, "t5_tbl_oor");
    rd_chk(1, 6'd5, 32'd0, "t5_unmapped");
    sb_drain(1, "t5");
    wr(1, REG_CTRL, 32'h2);
    tick();
    rd_chk(1, REG_STATUS, 32'h0, "t5_stopped");

    // 6: reset during ISSUE, then a normal run
    wr(0, 6'd32, 32'h5);
    wr(0, 6'd33, make_cmd(16'd3, OP_WRITE, 6'd1));
    wr(0, 6'd35, make_cmd(16'd0, OP_END, 6'd0));
    wr(0, REG_CTRL, 32'h4);
    wait1 = 1'b1;
    wr(0, REG_CTRL, 32'h5);
    tick();
    chk("t6_in_issue", 32'(m_wr1), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_mwrite", 32'(m_wr1), 32'd0);
    chk("t6_rst_mcs", 32'(m_cs1), 32'd0);
    chk("t6_rst_readdata", rd1, 32'd0);
    wait1 = 1'b0;
    rd_chk(0, REG_STATUS, 32'h0, "t6_status");
    rd_chk(0, REG_CTRL, 32'h0, "t6_irqen");
    wr(0, 6'd32, 32'h5);
    wr(0, 6'd33, make_cmd(16'd3, OP_WRITE, 6'd1));
    wr(0, 6'd35, make_cmd(16'd0, OP_END, 6'd0));
    exp1.push_back({6'd1, 32'h5});
    wr(0, REG_CTRL, 32'h1);
    tick();
    chk("t6_restart", 32'(m_wr1), 32'd1);
    repeat (10) tick();
    rd_chk(0, REG_STATUS, 32'h2, "t6_done");
    sb_drain(0, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
